// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the ALU result stream and a FIFO-buffered LSU result stream
// onto the single register-file write port, tracking per-register pending LSU results.
module wb_arbiter #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [4:0]  alu_waddr,
   input  logic [31:0] alu_wdata,
   output logic        alu_stall,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [4:0]  lsu_waddr,
   input  logic [31:0] lsu_wdata,
   output logic [31:0] pending,
   output logic        we,
   output logic [4:0]  waddr,
   output logic [31:0] wdata
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [7:0]    STARVE_C = 8'(STARVE_MAX);

   logic [4:0]    addr_mem [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [7:0]    starve_reg, starve_next;
   logic          stall_reg, stall_next;
   logic          we_reg;
   logic [4:0]    waddr_reg;
   logic [31:0]   wdata_reg;
   logic [31:0]   pending_reg, pending_next;

   logic          enq, deq, empty;
   logic [4:0]    head_addr;
   logic [31:0]   head_data;
   logic          sel_valid;
   logic [4:0]    sel_addr;
   logic [31:0]   sel_data;

   assign empty     = (count_reg == '0);
   assign lsu_ready = (count_reg < DEPTH_C);
   assign enq       = lsu_valid && lsu_ready;
   assign deq       = !alu_valid && !empty;
   assign head_addr = addr_mem[rd_ptr_reg];
   assign head_data = data_mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (enq) begin
         addr_mem[wr_ptr_reg] <= lsu_waddr;
         data_mem[wr_ptr_reg] <= lsu_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({enq, deq})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // The ALU always wins; idle cycles hold address/data so only we toggles.
   always_comb begin
      sel_valid = 1'b0;
      sel_addr  = waddr_reg;
      sel_data  = wdata_reg;
      if (alu_valid) begin
         sel_valid = 1'b1;
         sel_addr  = alu_waddr;
         sel_data  = alu_wdata;
      end else if (deq) begin
         sel_valid = 1'b1;
         sel_addr  = head_addr;
         sel_data  = head_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_reg    <= 1'b0;
         waddr_reg <= '0;
         wdata_reg <= '0;
      end else begin
         we_reg    <= sel_valid && (sel_addr != 5'd0);
         waddr_reg <= sel_addr;
         wdata_reg <= sel_data;
      end
   end

   // Counter is compared one step ahead so the stall lands right after the last blocked cycle.
   always_comb begin
      starve_next = starve_reg;
      stall_next  = 1'b0;
      if (deq || empty) begin
         starve_next = '0;
      end else if (starve_reg + 8'd1 == STARVE_C) begin
         starve_next = '0;
         stall_next  = 1'b1;
      end else begin
         starve_next = starve_reg + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_reg <= '0;
         stall_reg  <= 1'b0;
      end else begin
         starve_reg <= starve_next;
         stall_reg  <= stall_next;
      end
   end

   // Register 0 is never tracked; a same-cycle set beats the clear.
   assign pending_next[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < 32; gi++) begin : g_pending
         assign pending_next[gi] = (enq && (lsu_waddr == 5'(gi))) ||
                                   (pending_reg[gi] && !(deq && (head_addr == 5'(gi))));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pending_reg <= '0;
      else      pending_reg <= pending_next;
   end

   assign alu_stall = stall_reg;
   assign pending   = pending_reg;
   assign we        = we_reg;
   assign waddr     = waddr_reg;
   assign wdata     = wdata_reg;
endmodule
